// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller for the 32-deep asynchronous FIFO. It synchronises the Gray write pointer, owns the read pointer and generates read-domain status.
// Define RD_UNDERFLOW_STICKY_EN to make underflow sticky until reset. Without it, underflow is a one-cycle pulse.
module async_fifo_rd_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  rclk,
    input  logic                  hw_rst,
    input  logic                  sw_rst,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] aempty_value,
    input  logic [ADDR_WIDTH:0]   wptr_gray,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  rdempty,
    output logic                  rd_almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   fifo_read_count,
    output logic [ADDR_WIDTH:0]   rd_level
);

    localparam int PW = ADDR_WIDTH + 1;

    function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] wq_gray;
    logic [PW-1:0] wq_bin;
    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] next_rptr_bin;
    logic          rst;
    logic          rd_go;
    logic          rd_bad;
    logic          underflow_next;

    assign rst     = hw_rst | sw_rst;
    assign wq_gray = sync_q[SYNC_STAGES-1];
    assign wq_bin  = gray_to_bin(wq_gray);

    // Both pointers are registered, so comparing them in Gray form is glitch-free.
    assign rdempty         = (wq_gray == rptr_gray);
    assign rd_level        = wq_bin - rptr_bin;
    assign rd_almost_empty = (rd_level <= {1'b0, aempty_value});
    assign raddr           = rptr_bin[ADDR_WIDTH-1:0];

    assign rd_go         = read_enable & ~rdempty;
    assign rd_bad        = read_enable & rdempty;
    assign next_rptr_bin = rptr_bin + PW'(rd_go);

`ifdef RD_UNDERFLOW_STICKY_EN
    assign underflow_next = underflow | rd_bad;
`else
    assign underflow_next = rd_bad;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values. This includes the synchroniser chain.
    always_ff @(posedge rclk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            rptr_bin        <= '0;
            rptr_gray       <= '0;
            rdata           <= '0;
            rdata_valid     <= 1'b0;
            underflow       <= 1'b0;
            fifo_read_count <= '0;
        end else begin
            sync_q[0] <= wptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            rptr_bin    <= next_rptr_bin;
            rptr_gray   <= next_rptr_bin ^ (next_rptr_bin >> 1);
            rdata_valid <= rd_go;
            underflow   <= underflow_next;
            if (rd_go) begin
                rdata           <= mem_rdata;
                fifo_read_count <= fifo_read_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Randomised and directed bench for async_fifo_rd_ctrl. A queue-level reference model tracks the write count, the read count and the synchroniser delay.
module tb_async_fifo_rd_ctrl;

    localparam int SYNC  = 2;
    localparam int DEPTH = 32;

    logic        rclk = 1'b0;
    logic        hw_rst = 1'b1;
    logic        sw_rst = 1'b0;
    logic        read_enable = 1'b0;
    logic [4:0]  aempty_value = '0;
    logic [5:0]  wptr_gray = '0;
    logic [31:0] mem_rdata;
    logic [4:0]  raddr;
    logic [5:0]  rptr_gray;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        rdempty;
    logic        rd_almost_empty;
    logic        underflow;
    logic [5:0]  fifo_read_count;
    logic [5:0]  rd_level;

    logic [31:0] mem [DEPTH];
    int checks = 0;
    int errors = 0;

    // Reference model: entries written, entries read, and the write count the reader can currently see.
    logic [5:0]  m_wptr = '0;
    logic [5:0]  m_rptr = '0;
    logic [5:0]  m_count = '0;
    logic [5:0]  m_wvis = '0;
    logic [5:0]  m_hist [SYNC];
    logic [31:0] m_rdata = '0;
    logic        m_valid = 1'b0;
    logic        m_under = 1'b0;

    assign mem_rdata = mem[raddr];

    always #5 rclk = ~rclk;

    async_fifo_rd_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SYNC_STAGES(SYNC)) dut (
        .rclk(rclk), .hw_rst(hw_rst), .sw_rst(sw_rst), .read_enable(read_enable),
        .aempty_value(aempty_value), .wptr_gray(wptr_gray), .mem_rdata(mem_rdata),
        .raddr(raddr), .rptr_gray(rptr_gray), .rdata(rdata), .rdata_valid(rdata_valid),
        .rdempty(rdempty), .rd_almost_empty(rd_almost_empty), .underflow(underflow),
        .fifo_read_count(fifo_read_count), .rd_level(rd_level)
    );

    function automatic logic [5:0] gray(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic set_wptr(input logic [5:0] v);
        m_wptr    = v;
        wptr_gray = gray(v);
    endtask

    // Advance one edge and update the model from the inputs that were present at that edge.
    task automatic cycle();
        logic was_empty;
        @(posedge rclk);
        was_empty = (m_wvis == m_rptr);
        if (hw_rst || sw_rst) begin
            m_rptr = '0; m_count = '0; m_rdata = '0; m_valid = 1'b0; m_under = 1'b0;
            for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
        end else begin
            m_valid = read_enable && !was_empty;
            if (m_valid) begin
                m_rdata = mem[m_rptr[4:0]];
                m_rptr  = m_rptr + 6'd1;
                m_count = m_count + 6'd1;
            end
`ifdef RD_UNDERFLOW_STICKY_EN
            m_under = m_under || (read_enable && was_empty);
`else
            m_under = read_enable && was_empty;
`endif
            for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = m_wptr;
        end
        m_wvis = m_hist[SYNC-1];
        #1;
    endtask

    task automatic hard_reset();
        hw_rst = 1'b1; sw_rst = 1'b0; read_enable = 1'b0;
        set_wptr(6'd0);
        cycle();
        hw_rst = 1'b0;
    endtask

    task automatic test_reset();
        hw_rst = 1'b1;
        cycle();
        cycle();
        hw_rst = 1'b0;
        checks += 8;
        if (rdempty !== 1'b1) begin errors++; $display("FAIL reset_rdempty got %0b want 1", rdempty); end
        if (rd_almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %0b want 1", rd_almost_empty); end
        if (rd_level !== 6'd0) begin errors++; $display("FAIL reset_level got %0d want 0", rd_level); end
        if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %0b want 0", underflow); end
        if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %0h want 0", rdata); end
        if (rptr_gray !== 6'd0) begin errors++; $display("FAIL reset_rptr_gray got %0h want 0", rptr_gray); end
        if (rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", rdata_valid); end
        if (raddr !== 5'd0) begin errors++; $display("FAIL reset_raddr got %0d want 0", raddr); end
    endtask

    task automatic test_basic_read();
        set_wptr(6'd3);
        cycle();
        checks++;
        if (rd_level !== 6'd0) begin errors++; $display("FAIL sync_latency1 got %0d want 0", rd_level); end
        cycle();
        checks += 2;
        if (rd_level !== 6'd3) begin errors++; $display("FAIL sync_latency2 got %0d want 3", rd_level); end
        if (rdempty !== 1'b0) begin errors++; $display("FAIL basic_not_empty got %0b want 0", rdempty); end
        for (int i = 0; i < 3; i++) begin
            read_enable = 1'b1;
            cycle();
            checks += 2;
            if (rdata_valid !== 1'b1) begin errors++; $display("FAIL basic_valid%0d got %0b want 1", i, rdata_valid); end
            if (rdata !== mem[i]) begin errors++; $display("FAIL basic_rdata%0d got %0h want %0h", i, rdata, mem[i]); end
        end
        read_enable = 1'b0;
        cycle();
        checks += 3;
        if (rdata_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %0b want 0", rdata_valid); end
        if (rdempty !== 1'b1) begin errors++; $display("FAIL basic_empty got %0b want 1", rdempty); end
        if (fifo_read_count !== 6'd3) begin errors++; $display("FAIL basic_count got %0d want 3", fifo_read_count); end
    endtask

    task automatic test_underflow();
        logic [5:0] g0;
        logic       want_after;
        g0 = rptr_gray;
        read_enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks += 3;
            if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_pulse%0d got %0b want 1", i, underflow); end
            if (rptr_gray !== g0) begin errors++; $display("FAIL underflow_ptr%0d got %0h want %0h", i, rptr_gray, g0); end
            if (rdata_valid !== 1'b0) begin errors++; $display("FAIL underflow_valid%0d got %0b want 0", i, rdata_valid); end
        end
        read_enable = 1'b0;
        cycle();
`ifdef RD_UNDERFLOW_STICKY_EN
        want_after = 1'b1;
`else
        want_after = 1'b0;
`endif
        checks += 2;
        if (underflow !== want_after) begin errors++; $display("FAIL underflow_after got %0b want %0b", underflow, want_after); end
        if (fifo_read_count !== 6'd3) begin errors++; $display("FAIL underflow_count got %0d want 3", fifo_read_count); end
        sw_rst = 1'b1;
        cycle();
        sw_rst = 1'b0;
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear got %0b want 0", underflow); end
    endtask

    task automatic test_wrap();
        hard_reset();
        set_wptr(6'd32);
        cycle();
        cycle();
        checks += 2;
        if (rd_level !== 6'd32) begin errors++; $display("FAIL wrap_full_level got %0d want 32", rd_level); end
        if (rdempty !== 1'b0) begin errors++; $display("FAIL wrap_full_empty got %0b want 0", rdempty); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (raddr !== 5'(i)) begin errors++; $display("FAIL wrap_raddr%0d got %0d want %0d", i, raddr, i); end
            read_enable = 1'b1;
            cycle();
            checks += 2;
            if (rd_level !== 6'(31 - i)) begin errors++; $display("FAIL wrap_level%0d got %0d want %0d", i, rd_level, 31 - i); end
            if (rdata !== mem[i]) begin errors++; $display("FAIL wrap_rdata%0d got %0h want %0h", i, rdata, mem[i]); end
        end
        read_enable = 1'b0;
        checks += 4;
        if (rptr_gray !== 6'b110000) begin errors++; $display("FAIL wrap_rptr_gray got %0b want 110000", rptr_gray); end
        if (raddr !== 5'd0) begin errors++; $display("FAIL wrap_raddr_end got %0d want 0", raddr); end
        if (rdempty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %0b want 1", rdempty); end
        if (fifo_read_count !== 6'd32) begin errors++; $display("FAIL wrap_count32 got %0d want 32", fifo_read_count); end
        for (int i = 0; i < 40; i++) begin
            if (i < 32) begin
                mem[i] = $urandom;
                set_wptr(m_wptr + 6'd1);
            end
            read_enable = 1'b1;
            cycle();
            checks += 2;
            if (rdata_valid !== m_valid) begin errors++; $display("FAIL wrap2_valid%0d got %0b want %0b", i, rdata_valid, m_valid); end
            if (rdata !== m_rdata) begin errors++; $display("FAIL wrap2_rdata%0d got %0h want %0h", i, rdata, m_rdata); end
        end
        read_enable = 1'b0;
        checks += 3;
        if (rptr_gray !== 6'd0) begin errors++; $display("FAIL wrap2_rptr got %0b want 0", rptr_gray); end
        if (fifo_read_count !== 6'd0) begin errors++; $display("FAIL wrap2_count got %0d want 0", fifo_read_count); end
        if (rdempty !== 1'b1) begin errors++; $display("FAIL wrap2_empty got %0b want 1", rdempty); end
    endtask

    task automatic test_almost_empty();
        hard_reset();
        aempty_value = 5'd4;
        set_wptr(6'd6);
        cycle();
        cycle();
        checks += 2;
        if (rd_level !== 6'd6) begin errors++; $display("FAIL ae_level6 got %0d want 6", rd_level); end
        if (rd_almost_empty !== 1'b0) begin errors++; $display("FAIL ae_at6 got %0b want 0", rd_almost_empty); end
        for (int i = 0; i < 3; i++) begin
            read_enable = 1'b1;
            cycle();
            checks += 2;
            if (rd_level !== 6'(5 - i)) begin errors++; $display("FAIL ae_level%0d got %0d want %0d", i, rd_level, 5 - i); end
            if (rd_almost_empty !== (i >= 1)) begin errors++; $display("FAIL ae_flag%0d got %0b want %0b", i, rd_almost_empty, i >= 1); end
        end
        read_enable = 1'b0;
    endtask

    task automatic test_sw_rst();
        hard_reset();
        set_wptr(6'd10);
        cycle();
        cycle();
        checks++;
        if (rd_level !== 6'd10) begin errors++; $display("FAIL swrst_level10 got %0d want 10", rd_level); end
        read_enable = 1'b1;
        sw_rst = 1'b1;
        cycle();
        sw_rst = 1'b0;
        read_enable = 1'b0;
        checks += 6;
        if (rdata_valid !== 1'b0) begin errors++; $display("FAIL swrst_valid got %0b want 0", rdata_valid); end
        if (underflow !== 1'b0) begin errors++; $display("FAIL swrst_underflow got %0b want 0", underflow); end
        if (fifo_read_count !== 6'd0) begin errors++; $display("FAIL swrst_count got %0d want 0", fifo_read_count); end
        if (rptr_gray !== 6'd0) begin errors++; $display("FAIL swrst_rptr got %0h want 0", rptr_gray); end
        if (rd_level !== 6'd0) begin errors++; $display("FAIL swrst_level got %0d want 0", rd_level); end
        if (rdata !== 32'd0) begin errors++; $display("FAIL swrst_rdata got %0h want 0", rdata); end
    endtask

    task automatic test_random();
        logic [5:0] e_level;
        hard_reset();
        for (int n = 0; n < 800; n++) begin
            read_enable = ($urandom_range(0, 3) != 0);
            sw_rst      = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) aempty_value = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1 && 6'(m_wptr - m_rptr) < 6'd32) begin
                mem[m_wptr[4:0]] = $urandom;
                set_wptr(m_wptr + 6'd1);
            end
            cycle();
            e_level = m_wvis - m_rptr;
            checks += 9;
            if (rd_level !== e_level) begin errors++; $display("FAIL rnd_level@%0d got %0d want %0d", n, rd_level, e_level); end
            if (rdempty !== (e_level == 0)) begin errors++; $display("FAIL rnd_empty@%0d got %0b want %0b", n, rdempty, e_level == 0); end
            if (rd_almost_empty !== (e_level <= {1'b0, aempty_value})) begin
                errors++; $display("FAIL rnd_aempty@%0d got %0b level %0d thr %0d", n, rd_almost_empty, e_level, aempty_value);
            end
            if (raddr !== m_rptr[4:0]) begin errors++; $display("FAIL rnd_raddr@%0d got %0d want %0d", n, raddr, m_rptr[4:0]); end
            if (rptr_gray !== gray(m_rptr)) begin errors++; $display("FAIL rnd_rptr_gray@%0d got %0h want %0h", n, rptr_gray, gray(m_rptr)); end
            if (rdata_valid !== m_valid) begin errors++; $display("FAIL rnd_valid@%0d got %0b want %0b", n, rdata_valid, m_valid); end
            if (rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata@%0d got %0h want %0h", n, rdata, m_rdata); end
            if (underflow !== m_under) begin errors++; $display("FAIL rnd_underflow@%0d got %0b want %0b", n, underflow, m_under); end
            if (fifo_read_count !== m_count) begin errors++; $display("FAIL rnd_count@%0d got %0d want %0d", n, fifo_read_count, m_count); end
        end
        sw_rst = 1'b0;
        read_enable = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
        test_reset();
        test_basic_read();
        test_underflow();
        test_wrap();
        test_almost_empty();
        test_sw_rst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/async_fifo_rd_ctrl.md
Name: async_fifo_rd_ctrl

Overview:
- Read-domain control for the team's 32-deep, 32-bit asynchronous FIFO; the counterpart of the write-side controller.
- Synchronises the write pointer (Gray code) into rclk and maintains the read pointer.
- Drives the memory read address and captures read data.
- Generates empty, almost-empty, underflow, read count and level status in the read domain.

Parameters:
- DATA_WIDTH, 32, width of rdata / mem_rdata.
- ADDR_WIDTH, 5, memory address width; FIFO depth = 2**ADDR_WIDTH.
- SYNC_STAGES, 2, number of flops in the wptr_gray synchroniser (minimum 2).

Ports:
- rclk  input  1  read-domain clock; all state updates on posedge.
- hw_rst  input  1  reset; synchronous to rclk, active-high.
- sw_rst  input  1  soft reset; synchronous, active-high; same effect as hw_rst.
- read_enable  input  1  read request.
- aempty_value  input  ADDR_WIDTH  almost-empty threshold.
- wptr_gray  input  ADDR_WIDTH+1  write pointer in Gray code, from the wclk domain (asynchronous).
- mem_rdata  input  DATA_WIDTH  combinational read data from memory at raddr.
- raddr  output  ADDR_WIDTH  memory read address.
- rptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain.
- rdata  output  DATA_WIDTH  captured read data.
- rdata_valid  output  1  one-cycle strobe qualifying rdata.
- rdempty  output  1  FIFO empty in the read domain.
- rd_almost_empty  output  1  level at or below threshold.
- underflow  output  1  read attempted while empty.
- fifo_read_count  output  ADDR_WIDTH+1  successful reads, modulo 2**(ADDR_WIDTH+1).
- rd_level  output  ADDR_WIDTH+1  entries visible to the reader.

Behaviour:
- Interface (decided): one clock, rclk. Reset hw_rst is synchronous and active-high.
- Reset priority: hw_rst > sw_rst > normal operation. Either reset, on the next posedge, clears to 0:
  - rptr_bin, rptr_gray, all synchroniser flops, rdata, rdata_valid, underflow, fifo_read_count.
  - After reset, rdempty=1, rd_level=0, raddr=0, and rd_almost_empty=1 (0 <= any threshold).
- Synchroniser:
  - wptr_gray passes through SYNC_STAGES flops to give wq_gray; wq_bin = Gray-to-binary of wq_gray.
  - Latency from a wptr_gray change to a rd_level update is SYNC_STAGES cycles.
- Read pointer:
  - rptr_bin has ADDR_WIDTH+1 bits. raddr = rptr_bin[ADDR_WIDTH-1:0].
  - rptr_gray is registered as next_rptr_bin ^ (next_rptr_bin>>1), so it changes in the same cycle as rptr_bin and never glitches.
- Accepted read: rd_go = read_enable & ~rdempty. On a posedge with rd_go:
  - rdata <= mem_rdata (data at the old raddr); rdata_valid <= 1.
  - rptr_bin increments; fifo_read_count increments.
  - Latency: data valid one cycle after the request.
- rdata_valid is 0 on any cycle without rd_go. rdata holds its last value.
- Status outputs are combinational from registered state:
  - rd_level = wq_bin - rptr_bin, modulo 2**(ADDR_WIDTH+1); range 0..32.
  - rdempty = (wq_gray == rptr_gray).
  - rd_almost_empty = (rd_level <= aempty_value).
- Underflow: read_enable & rdempty sets underflow=1 on the next cycle, as a one-cycle pulse.
  - The pointer, rdata and count are unchanged.
  - Consecutive illegal reads give consecutive pulses.
- Wrap-around: the pointer MSB toggles every 32 reads, so full/empty are distinguished by the MSB. fifo_read_count wraps 63 -> 0.
- Read on the last entry (rd_level=1):
  - The read is accepted and rdempty=1 the next cycle.
  - A read in that next cycle is an underflow.
- A write landing while reading: rd_level reflects it SYNC_STAGES cycles later. Reads never see data early.
- Reset mid-operation:
  - A read request in the same cycle as a reset is ignored, with no underflow.
  - Outputs take their reset values on the next edge.

Optional Feature:
- Macro: RD_UNDERFLOW_STICKY_EN.
- Defined: underflow is sticky. Once set, it stays 1 until hw_rst or sw_rst.
- Undefined: underflow is a one-cycle pulse per illegal read, as described above.

Test Plan:
- hw_rst=1 for 2 cycles -> rdempty=1, rd_almost_empty=1, rd_level=0, underflow=0, rdata=0, rptr_gray=0.
- Drive wptr_gray to Gray(3)=6'b000010 -> after 2 cycles rd_level=3, rdempty=0. Three reads -> rdata_valid asserted 3 cycles with mem_rdata from raddr 0,1,2; then rdempty=1 and fifo_read_count=3.
- With rd_level=0, read_enable=1 for 2 cycles -> underflow pulses 2 cycles, rptr_gray stays constant. Repeat with RD_UNDERFLOW_STICKY_EN -> underflow stays 1 until sw_rst.
- Write pointer at 32, 32 reads -> rd_level 32->0, raddr wraps 31->0, rptr_bin=6'b100000, rdempty=1. Further 32 writes/reads -> rptr_bin=0, fifo_read_count=0.
- aempty_value=4, rd_level stepped 6->3 by reads -> rd_almost_empty goes 0 to 1 when rd_level reaches 4.
- sw_rst asserted with rd_level=10 and read_enable=1 -> no read accepted, next cycle all counters/pointers 0, rdata_valid=0, no underflow.
